// File: rtl/ahb_ram_bridge_pkg.sv
// Shared encodings for the AHB-Lite to multi-channel RAM bridge: bus codes,
// bridge FSM states and CSR byte offsets.
package ahb_ram_bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [3:0] CSR_CTRL    = 4'h0;
    localparam logic [3:0] CSR_STATUS  = 4'h4;
    localparam logic [3:0] CSR_INT_CLR = 4'h8;
    localparam logic [3:0] CSR_INT_EN  = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Byte-lane mask for an AHB transfer size; only sizes up to a word are legal.
    function automatic logic [3:0] size_mask(input logic [2:0] hsize);
        case (hsize)
            HSIZE_BYTE: return 4'h1;
            HSIZE_HALF: return 4'h3;
            default:    return 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/ahb_ram_csr.sv
// Host/accelerator control registers: channel ownership, start pulse,
// sticky done flag with interrupt enable and a registered irq.
module ahb_ram_csr
    import ahb_ram_bridge_pkg::*;
#(
    parameter int NUM_CH = 5
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              wr_en,
    input  logic [1:0]        off,
    input  logic [31:0]       wdata,
    input  logic              done,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] owner,
    output logic [NUM_CH-1:0] owner_nxt,
    output logic              start,
    output logic              irq
);

    logic       done_sticky;
    logic       int_en;
    logic [3:0] boff;
    logic       wr_ctrl;
    logic       wr_clr;
    logic       wr_ie;
    logic       unused_bits;

    assign boff    = {off, 2'b00};
    assign wr_ctrl = wr_en && (boff == CSR_CTRL);
    assign wr_clr  = wr_en && (boff == CSR_INT_CLR) && wdata[0];
    assign wr_ie   = wr_en && (boff == CSR_INT_EN);

    // Lets the decoder see an ownership change in the same cycle it is written.
    assign owner_nxt = wr_ctrl ? wdata[NUM_CH-1:0] : owner;

    assign unused_bits = ^wdata[30:NUM_CH];

    always_comb begin
        rdata = '0;
        case (boff)
            CSR_CTRL:   rdata = 32'(owner);
            CSR_STATUS: rdata = {31'b0, done_sticky};
            CSR_INT_EN: rdata = {31'b0, int_en};
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            owner       <= '0;
            start       <= 1'b0;
            int_en      <= 1'b0;
            done_sticky <= 1'b0;
            irq         <= 1'b0;
        end else begin
            owner <= owner_nxt;
            start <= wr_ctrl && wdata[31];
            if (wr_ie)
                int_en <= wdata[0];
            // A new done in the same cycle as a clear keeps the flag set.
            done_sticky <= done | (done_sticky & ~wr_clr);
            irq         <= done_sticky & int_en;
        end
    end

endmodule

// File: rtl/ahb_ram_bridge.sv
// AHB-Lite slave mapping a flat window onto NUM_CH RAM channels plus a CSR
// bank; decodes, checks and sequences wait/error responses per transfer.
module ahb_ram_bridge
    import ahb_ram_bridge_pkg::*;
#(
    parameter int NUM_CH     = 5,
    parameter int RAM_AW     = 10,
    parameter int RAM_DW     = 64,
    parameter int RAM_RD_LAT = 1
) (
    input  logic                     hclk,
    input  logic                     hresetn,
    input  logic                     hsel,
    input  logic                     hwrite,
    input  logic [31:0]              haddr,
    input  logic [1:0]               htrans,
    input  logic [2:0]               hsize,
    input  logic [2:0]               hburst,
    input  logic [31:0]              hwdata,
    output logic [31:0]              hrdata,
    output logic [1:0]               hresp,
    output logic                     hready,
    output logic [NUM_CH-1:0]        ram_wen,
    output logic [RAM_AW-1:0]        ram_waddr,
    output logic [RAM_DW-1:0]        ram_wdata,
    output logic [RAM_DW/8-1:0]      ram_wbe,
    output logic [NUM_CH-1:0]        ram_ren,
    output logic [RAM_AW-1:0]        ram_raddr,
    input  logic [NUM_CH*RAM_DW-1:0] ram_rdata,
    output logic [NUM_CH-1:0]        ram_owner,
    output logic                     start,
    input  logic                     done,
    output logic                     irq
);

    localparam int NB   = RAM_DW / 8;
    localparam int NL   = RAM_DW / 32;
    localparam int BW   = $clog2(NB);
    localparam int WIN  = RAM_AW + BW;
    localparam int CH_W = $clog2(NUM_CH + 1);
    localparam logic [1:0] LAST_CNT = 2'(RAM_RD_LAT - 1);

    state_t state, state_nxt;
    logic [1:0]        cnt;
    logic              rd_done;
    logic              dp_wr;
    logic              dp_csr_wr;
    logic              dp_csr_rd;
    logic [CH_W-1:0]   dp_ch;
    logic [RAM_AW-1:0] dp_addr;
    logic [BW-1:0]     dp_boff;
    logic [2:0]        dp_size;
    logic [1:0]        dp_off;
    logic [NUM_CH-1:0] owner_nxt;
    logic [31:0]       csr_rdata;
    logic [RAM_DW-1:0] rword;
    logic [31:0]       rlane;

    logic [CH_W-1:0]   a_ch;
    logic              a_csr;
    logic              a_owned;
    logic              a_err;
    logic              trans_act;
    logic              accept;
    logic              rd_start;
    logic              unused_bits;

    assign unused_bits = ^{hburst, haddr[31:WIN+CH_W]};

    // ---- address-phase decode ----
    assign a_ch      = haddr[WIN +: CH_W];
    assign a_csr     = (a_ch == CH_W'(NUM_CH));
    assign trans_act = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign hready    = (state == ST_IDLE) || (state == ST_ERR2);
    assign accept    = hsel && trans_act && hready;

    always_comb begin
        a_owned = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            if (a_ch == CH_W'(c))
                a_owned = owner_nxt[c];
    end

    assign a_err = (hsize > HSIZE_WORD)
                 || ((hsize == HSIZE_HALF) && haddr[0])
                 || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00))
                 || (a_ch > CH_W'(NUM_CH))
                 || a_owned
                 || (a_csr && (haddr[WIN-1:4] != '0));

    assign rd_start = accept && !a_err && !a_csr && !hwrite;

    // ---- data-phase registers ----
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_wr     <= 1'b0;
            dp_csr_wr <= 1'b0;
            dp_csr_rd <= 1'b0;
            dp_ch     <= '0;
            dp_addr   <= '0;
            dp_boff   <= '0;
            dp_size   <= '0;
            dp_off    <= '0;
        end else begin
            dp_wr     <= accept && !a_err && !a_csr && hwrite;
            dp_csr_wr <= accept && !a_err && a_csr && hwrite;
            dp_csr_rd <= accept && !a_err && a_csr && !hwrite;
            if (accept) begin
                dp_ch   <= a_ch;
                dp_addr <= haddr[WIN-1:BW];
                dp_boff <= haddr[BW-1:0];
                dp_size <= hsize;
                dp_off  <= haddr[3:2];
            end
        end
    end

    // ---- bridge FSM ----
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hresp     = HRESP_OKAY;
        case (state)
            ST_IDLE, ST_ERR2: begin
                if (state == ST_ERR2)
                    hresp = HRESP_ERROR;
                if (accept && a_err)
                    state_nxt = ST_ERR1;
                else if (rd_start)
                    state_nxt = ST_RD_WAIT;
                else
                    state_nxt = ST_IDLE;
            end
            ST_RD_WAIT: begin
                if (cnt == LAST_CNT)
                    state_nxt = ST_IDLE;
            end
            ST_ERR1: begin
                hresp     = HRESP_ERROR;
                state_nxt = ST_ERR2;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Counts RAM latency cycles; rd_done marks the completion cycle back in IDLE.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cnt     <= '0;
            rd_done <= 1'b0;
        end else begin
            rd_done <= (state == ST_RD_WAIT) && (cnt == LAST_CNT);
            if ((state == ST_RD_WAIT) && (cnt != LAST_CNT))
                cnt <= cnt + 2'd1;
            else
                cnt <= '0;
        end
    end

    // ---- RAM side ----
    always_comb begin
        ram_wen = '0;
        ram_ren = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ram_wen[c] = dp_wr && (dp_ch == CH_W'(c));
            ram_ren[c] = (state == ST_RD_WAIT) && (cnt == 2'd0) && (dp_ch == CH_W'(c));
        end
    end

    assign ram_waddr = dp_addr;
    assign ram_raddr = dp_addr;
    assign ram_wdata = dp_wr ? {NL{hwdata}} : '0;
    assign ram_wbe   = dp_wr ? NB'(NB'(size_mask(dp_size)) << dp_boff) : '0;

    always_comb begin
        rword = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (dp_ch == CH_W'(c))
                rword = ram_rdata[c*RAM_DW +: RAM_DW];
        rlane = '0;
        for (int l = 0; l < NL; l++)
            if (int'(dp_boff >> 2) == l)
                rlane = rword[l*32 +: 32];
    end

    assign hrdata = rd_done ? rlane : (dp_csr_rd ? csr_rdata : '0);

    ahb_ram_csr #(
        .NUM_CH (NUM_CH)
    ) u_csr (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .wr_en     (dp_csr_wr),
        .off       (dp_off),
        .wdata     (hwdata),
        .done      (done),
        .rdata     (csr_rdata),
        .owner     (ram_owner),
        .owner_nxt (owner_nxt),
        .start     (start),
        .irq       (irq)
    );

endmodule

// File: doc/ahb_ram_bridge.md
# ahb_ram_bridge

Parametrised AHB-Lite slave that maps a flat AHB window onto `NUM_CH` independent single-port-style RAM channels plus a small CSR bank. It is the next generation of the accelerator host interface. It adds configurable channel count and RAM width, read wait states for multi-cycle RAM latency, byte-enable writes, ERROR responses, and per-channel ownership locking between host and accelerator. It sits between the system AHB fabric and the accelerator's parameter/feature RAMs.

## Interface
Parameters:
- `NUM_CH`, 5: number of RAM channels (1..15).
- `RAM_AW`, 10: RAM word-address width per channel.
- `RAM_DW`, 64: RAM data width; 32 or 64.
- `RAM_RD_LAT`, 1: RAM read latency in cycles (1..3).

Ports. One clock; reset is asynchronous and active-low.
- `hclk` in 1: clock.
- `hresetn` in 1: async active-low reset.
- `hsel`, `hwrite` in 1; `haddr` in 32; `htrans` in 2; `hsize`, `hburst` in 3; `hwdata` in 32: AHB-Lite inputs. `hburst` is ignored.
- `hrdata` out 32; `hresp` out 2; `hready` out 1: AHB-Lite outputs.
- `ram_wen` out NUM_CH: per-channel write strobe.
- `ram_waddr` out RAM_AW: shared write word address.
- `ram_wdata` out RAM_DW: `hwdata` replicated RAM_DW/32 times.
- `ram_wbe` out RAM_DW/8: byte enables.
- `ram_ren` out NUM_CH: per-channel read strobe.
- `ram_raddr` out RAM_AW: shared read word address.
- `ram_rdata` in NUM_CH*RAM_DW: channel c occupies bits [c*RAM_DW +: RAM_DW].
- `ram_owner` out NUM_CH: 1 means the accelerator owns the channel.
- `start` out 1: one-cycle start pulse.
- `done` in 1: accelerator completion pulse.
- `irq` out 1: level interrupt.

## Operation
- Address fields:
  - BW = log2(RAM_DW/8) and WIN = RAM_AW + BW.
  - Channel index = `haddr[WIN +: clog2(NUM_CH+1)]`.
  - Word address = `haddr[WIN-1:BW]`.
  - Higher bits are ignored.
  - Index NUM_CH selects the CSR bank.
- A transfer is accepted when `hsel & htrans[1] & hready`. The address, control and channel are registered for the data phase.
- IDLE and BUSY transfers get zero-wait OKAY responses.
- ERROR is returned when any of the following holds:
  - `hsize` > 2;
  - the address is misaligned for its size;
  - the channel index > NUM_CH;
  - the target channel has `ram_owner`=1;
  - the CSR offset is undefined.
- No RAM strobe is issued for an errored transfer.
- Write data phase, issued in the first data-phase cycle with zero wait:
  - `ram_wen[ch]`=1;
  - `ram_wbe` = size mask (1/3/F) shifted by `haddr[BW-1:0]`.
- Read data phase: `ram_ren[ch]`=1 in the first data-phase cycle. `hrdata` = the 32-bit lane selected by `haddr[BW-1:2]` of `ram_rdata[ch]`.
- CSR bank (word offsets):
  - 0x0 CTRL RW: bits [NUM_CH-1:0] = `ram_owner`. Writing 1 to bit 31 pulses `start`; bit 31 reads 0.
  - 0x4 STATUS RO: bit0 = done_sticky.
  - 0x8 INT_CLR W1C: bit0 clears done_sticky.
  - 0xC INT_EN RW: bit0.
- `irq` = done_sticky & INT_EN[0], registered.
- If `done` and an INT_CLR write occur in the same cycle, the set wins.
- FSM states and transitions:
  - IDLE → RD_WAIT on an accepted RAM read.
  - IDLE → ERR1 on an error.
  - RD_WAIT → IDLE after RAM_RD_LAT cycles.
  - ERR1 → ERR2 → IDLE.
  - ERR2 may accept a new transfer.

## Timing
- Reset values:
  - `hready`=1, `hresp`=OKAY, `hrdata`=0;
  - all `ram_wen`, `ram_ren` = 0; address and data buses 0; `ram_wbe`=0;
  - `ram_owner`=0, `start`=0, `irq`=0;
  - CSRs 0; FSM in IDLE.
- RAM write: zero wait states; `hready` stays 1.
- RAM read: `ram_ren` fires in data-phase cycle D0. `hready`=0 for D0 .. D0+LAT-1. In D0+LAT, `hready`=1 and `hrdata` is valid.
- CSR read and write: zero wait. Read data is valid in the first data-phase cycle. A CSR write takes effect on the following edge.
- ERROR: cycle 1 drives `hresp`=01 with `hready`=0. Cycle 2 drives `hresp`=01 with `hready`=1.
- `hrdata` is 0 in every cycle that is not a read completion.
- `start` is high for exactly one cycle, on the cycle after the CTRL write data phase.
- Reset asserted mid-read or mid-error aborts immediately to the reset values. There is no RAM strobe after reset release until a new transfer.
- The ownership check uses `ram_owner` at the address-phase edge. A CTRL write in the previous data phase is therefore already visible to a back-to-back transfer.

## Structure
- A package `ahb_ram_bridge_pkg` holds:
  - the HTRANS/HRESP/HSIZE encodings;
  - the FSM state enum;
  - the CSR offset constants.
- One sub-module, `ahb_ram_csr`, holds the CTRL/STATUS/INT registers, the start pulse and the irq. The bridge FSM and decoder stay in the top module.

## Test plan
- Word write of 0xDEADBEEF to ch2, offset 0x104 (RAM_DW=64): `ram_wen`=00100, `ram_waddr`=0x20, `ram_wbe`=0xF0, no wait state.
- Read back the same address with RAM_RD_LAT=2: `hready` is low for exactly 2 cycles, then `hrdata`=0xDEADBEEF with OKAY.
- Set CTRL=0x8000_0004, then access ch2: `start` pulses once; the ch2 access gets a two-cycle ERROR with no `ram_wen`/`ram_ren`; a ch1 access is still OKAY.
- Pulse `done` with INT_EN=1: `irq` rises; STATUS reads 1. An INT_CLR write of 1 coincident with a second `done` pulse leaves `irq`=1.
- Each of the following gives a two-cycle ERROR: `hsize`=3, a halfword at offset 0x1, channel index NUM_CH+1, CSR offset 0x10.
- Assert `hresetn` during RD_WAIT: `hready` returns to 1 and all strobes drop to 0 asynchronously; the next read after reset completes normally.
